// File: rtl/ipu_pkg.sv
// Shared types and IPU register-map constants for the IPU bus sequencer.
package ipu_pkg;

    typedef enum logic [2:0] {
        S_STAT    = 3'd0,
        S_TX_DATA = 3'd1,
        S_TX_GO   = 3'd2,
        S_TX_WAIT = 3'd3,
        S_RX_RD   = 3'd4,
        S_RX_CLR  = 3'd5
    } state_t;

    localparam logic [31:0] CTRL_SEND      = 32'h0000_0001;
    localparam logic [31:0] CTRL_RXCLR     = 32'h0000_0002;
    localparam logic        SEL_CTRL       = 1'b0;
    localparam logic        SEL_DATA       = 1'b1;
    localparam logic        ADDR_TX        = 1'b0;
    localparam logic        ADDR_RX        = 1'b1;
    localparam int          CTRL_BUSY_BIT  = 0;
    localparam int          CTRL_NEWRX_BIT = 1;

    // Round-robin side identifiers
    localparam logic        SIDE_TX        = 1'b0;
    localparam logic        SIDE_RX        = 1'b1;

    // States that hold a read address on the IPU port and wait for salida_i
    function automatic logic is_read_state(input state_t s);
        return (s == S_STAT) || (s == S_TX_WAIT) || (s == S_RX_RD);
    endfunction

endpackage

// File: rtl/ipu_rd_timer.sv
// Read-latency down-counter: loaded on start, done when the RD_LAT-th edge is due.
module ipu_rd_timer #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    localparam int W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [W-1:0] LOAD = W'(RD_LAT - 1);

    logic [W-1:0] cnt;

    // Count down from RD_LAT-1; zero means the next edge samples salida_i
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= LOAD;
        end else if (start) begin
            cnt <= LOAD;
        end else if (cnt != {W{1'b0}}) begin
            cnt <= cnt - W'(1);
        end else begin
            cnt <= cnt;
        end
    end

    assign done = (cnt == {W{1'b0}});

endmodule

// File: rtl/ipu_bus_sequencer.sv
// IPU register-port master: serves a TX byte stream and RX byte delivery over the
// single IPU port with round-robin arbitration between the two services.
module ipu_bus_sequencer
    import ipu_pkg::*;
#(
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_valid_i,
    input  logic [7:0]  tx_data_i,
    output logic        tx_ready_o,
    output logic        rx_valid_o,
    output logic [7:0]  rx_data_o,
    output logic        wr_o,
    output logic        reg_sel_o,
    output logic        addr_o,
    output logic [31:0] entrada_o,
    input  logic [31:0] salida_i,
    output logic        busy_o,
    output logic        err_o
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    state_t      state;
    state_t      state_nx;
    logic        rr_last;
    logic [TW-1:0] tmo_cnt;
    logic        rd_start;
    logic        rd_done;
    logic        rxp;
    logic        txp;
    logic        ipu_busy;
    logic        tmo_hit;

    logic        wr_nx;
    logic        reg_sel_nx;
    logic        addr_nx;
    logic [31:0] entrada_nx;
    logic        unused_salida;

    assign unused_salida = ^salida_i[31:8];

    ipu_rd_timer #(.RD_LAT(RD_LAT)) u_rd_timer (
        .clk   (clk),
        .rst   (rst),
        .start (rd_start),
        .done  (rd_done)
    );

    // Next-state selection, arbitration and read-window restart
    always_comb begin
        state_nx = state;
        rxp      = salida_i[CTRL_NEWRX_BIT];
        ipu_busy = salida_i[CTRL_BUSY_BIT];
        txp      = tx_valid_i && !ipu_busy;
        tmo_hit  = (tmo_cnt >= (TMO_MAX - TW'(1)));
        case (state)
            S_STAT: begin
                if (!rd_done) begin
                    state_nx = S_STAT;
                end else if (rxp && txp) begin
                    state_nx = (rr_last == SIDE_RX) ? S_TX_DATA : S_RX_RD;
                end else if (txp) begin
                    state_nx = S_TX_DATA;
                end else if (rxp) begin
                    state_nx = S_RX_RD;
                end else begin
                    state_nx = S_STAT;
                end
            end
            S_TX_DATA: state_nx = S_TX_GO;
            S_TX_GO:   state_nx = S_TX_WAIT;
            S_TX_WAIT: begin
                if (!rd_done) begin
                    state_nx = S_TX_WAIT;
                end else if (!ipu_busy || tmo_hit) begin
                    state_nx = S_STAT;
                end else begin
                    state_nx = S_TX_WAIT;
                end
            end
            S_RX_RD: begin
                if (rd_done) begin
                    state_nx = S_RX_CLR;
                end else begin
                    state_nx = S_RX_RD;
                end
            end
            S_RX_CLR:  state_nx = S_STAT;
            default:   state_nx = S_STAT;
        endcase
        // A new read window opens on entry to a read state or after each sample
        rd_start = is_read_state(state_nx) && (rd_done || !is_read_state(state));
    end

    // Port values for the coming cycle, decoded from the next state
    always_comb begin
        wr_nx      = 1'b0;
        reg_sel_nx = SEL_CTRL;
        addr_nx    = ADDR_TX;
        entrada_nx = 32'h0000_0000;
        case (state_nx)
            S_TX_DATA: begin
                wr_nx      = 1'b1;
                reg_sel_nx = SEL_DATA;
                addr_nx    = ADDR_TX;
                entrada_nx = {24'h00_0000, tx_data_i};
            end
            S_TX_GO: begin
                wr_nx      = 1'b1;
                entrada_nx = CTRL_SEND;
            end
            S_RX_RD: begin
                reg_sel_nx = SEL_DATA;
                addr_nx    = ADDR_RX;
            end
            S_RX_CLR: begin
                wr_nx      = 1'b1;
                entrada_nx = CTRL_RXCLR;
            end
            default: begin
                wr_nx      = 1'b0;
                reg_sel_nx = SEL_CTRL;
                addr_nx    = ADDR_TX;
                entrada_nx = 32'h0000_0000;
            end
        endcase
    end

    // FSM state, arbitration history, timeout counter and captured RX byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_STAT;
            rr_last   <= SIDE_RX;
            tmo_cnt   <= {TW{1'b0}};
            err_o     <= 1'b0;
            rx_data_o <= 8'h00;
        end else begin
            state <= state_nx;
            if (state == S_TX_GO) begin
                rr_last <= SIDE_TX;
                tmo_cnt <= {TW{1'b0}};
            end else if (state == S_RX_CLR) begin
                rr_last <= SIDE_RX;
            end
            if ((state == S_TX_WAIT) && rd_done && ipu_busy) begin
                if (tmo_cnt != TMO_MAX) begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
                if (tmo_hit) begin
                    err_o <= 1'b1;
                end
            end
            if ((state == S_RX_RD) && rd_done) begin
                rx_data_o <= salida_i[7:0];
            end
        end
    end

    // Registered IPU port and handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_o       <= 1'b0;
            reg_sel_o  <= 1'b0;
            addr_o     <= 1'b0;
            entrada_o  <= 32'h0000_0000;
            tx_ready_o <= 1'b0;
            rx_valid_o <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            wr_o       <= wr_nx;
            reg_sel_o  <= reg_sel_nx;
            addr_o     <= addr_nx;
            entrada_o  <= entrada_nx;
            tx_ready_o <= (state_nx == S_TX_DATA);
            rx_valid_o <= (state_nx == S_RX_CLR);
            busy_o     <= (state_nx != S_STAT);
        end
    end

endmodule

// File: tb/tb_ipu_bus_sequencer.sv
// Self-checking bench: behavioural IPU (TX busy timer, RX byte FIFO) plus scoreboards.
module tb_ipu_bus_sequencer;

    localparam int RD_LAT  = 1;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_valid_i = 1'b0;
    logic [7:0]  tx_data_i = 8'h00;
    logic        tx_ready_o, rx_valid_o, wr_o, reg_sel_o, addr_o, busy_o, err_o;
    logic [7:0]  rx_data_o;
    logic [31:0] entrada_o, salida_i;

    always #5 clk = ~clk;

    ipu_bus_sequencer #(.RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .tx_valid_i(tx_valid_i), .tx_data_i(tx_data_i),
        .tx_ready_o(tx_ready_o), .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o),
        .wr_o(wr_o), .reg_sel_o(reg_sel_o), .addr_o(addr_o), .entrada_o(entrada_o),
        .salida_i(salida_i), .busy_o(busy_o), .err_o(err_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] ipu_tx_log[$];
    logic [7:0] tx_exp[$];
    int         grants[$];

    int   busy_cnt = 0, busy_len = 4;
    logic stuck = 1'b0, stick_next = 1'b0;
    logic new_rx_m = 1'b0, busy_m = 1'b0;
    logic [7:0] rx_head_m = 8'h00, ipu_pending = 8'h00;
    logic prev_data_wr = 1'b0, prev_rx_rd = 1'b0, prev_busy = 1'b0, prev_err = 1'b0;
    int   cyc = 0, go_cyc = 0, fall_cyc = 0, err_cyc = 0;
    int   n_ready = 0, n_go = 0, n_rx = 0, n_rxv = 0;

    // IPU read port, RD_LAT=1: value follows the presented address
    assign salida_i = (!reg_sel_o) ? {30'h0, new_rx_m, busy_m}
                                   : (addr_o ? {24'h0, rx_head_m} : 32'h0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // IPU model and protocol monitor, evaluated mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            rxq.delete();
            busy_cnt = 0; stuck = 1'b0;
            prev_data_wr = 1'b0; prev_rx_rd = 1'b0; prev_busy = 1'b0; prev_err = 1'b0;
        end else begin
            cyc++;
            if (!wr_o) chk("entrada_idle", entrada_o, 32'h0);
            chk("tx_ready_rule", 32'(tx_ready_o), 32'(wr_o && reg_sel_o && !addr_o));
            chk("rx_valid_rule", 32'(rx_valid_o), 32'(wr_o && !reg_sel_o && entrada_o == 32'h2));
            if (prev_data_wr) chk("go_after_data", {30'h0, wr_o, reg_sel_o}, 32'h2);
            if (prev_err) chk("err_sticky", 32'(err_o), 32'h1);
            if (busy_cnt != 0) busy_cnt--;
            if (tx_ready_o) n_ready++;
            if (rx_valid_o) n_rxv++;
            if (wr_o && reg_sel_o) begin
                chk("data_wr_addr", 32'(addr_o), 32'h0);
                chk("data_wr_byte", entrada_o, (txq.size() != 0) ? {24'h0, txq[0]} : 32'hFFFF_FFFF);
                ipu_pending = entrada_o[7:0];
                grants.push_back(1);
                if (txq.size() != 0) void'(txq.pop_front());
            end else if (wr_o && entrada_o == 32'h1) begin
                chk("go_prev_data", 32'(prev_data_wr), 32'h1);
                ipu_tx_log.push_back(ipu_pending);
                busy_cnt = busy_len;
                if (stick_next) stuck = 1'b1;
                go_cyc = cyc;
                n_go++;
            end else if (wr_o) begin
                chk("ctrl_wr_value", entrada_o, 32'h2);
                chk("clr_prev_rd", 32'(prev_rx_rd), 32'h1);
                chk("rx_byte", {24'h0, rx_data_o}, (rxq.size() != 0) ? {24'h0, rxq[0]} : 32'hFFFF_FFFF);
                if (rxq.size() != 0) void'(rxq.pop_front());
                grants.push_back(2);
                n_rx++;
            end
            if (prev_busy && !busy_o) fall_cyc = cyc;
            if (!prev_err && err_o) err_cyc = cyc;
            prev_data_wr = wr_o && reg_sel_o;
            prev_rx_rd   = !wr_o && reg_sel_o && addr_o;
            prev_busy    = busy_o;
            prev_err     = err_o;
        end
        new_rx_m   = (rxq.size() != 0);
        rx_head_m  = new_rx_m ? rxq[0] : 8'h00;
        busy_m     = stuck || (busy_cnt != 0);
        tx_valid_i = (txq.size() != 0);
        tx_data_i  = tx_valid_i ? txq[0] : 8'h00;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        int   nr, ng, n0, nv;
        logic [7:0] b;

        // 1. Reset and idle polling
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", {17'h0, tx_ready_o, rx_valid_o, rx_data_o, wr_o, reg_sel_o, addr_o, busy_o, err_o}, 32'h0);
        chk("rst_entrada", entrada_o, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("idle_ctl", {29'h0, wr_o, reg_sel_o, busy_o}, 32'h0);
        end

        // 2. Single TX byte, IPU busy for 10 cycles
        busy_len = 10; nr = n_ready; ng = n_go;
        txq.push_back(8'hA5); tx_exp.push_back(8'hA5);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (n_go == ng + 1 && !busy_o) begin ok = 1'b1; break; end
        end
        chk("t2_done", 32'(ok), 32'h1);
        chk("t2_ready_once", n_ready - nr, 32'h1);
        chk("t2_busy_hold", fall_cyc - go_cyc, busy_len + 1);
        chk("t2_ipu_byte", {24'h0, ipu_tx_log[ipu_tx_log.size() - 1]}, 32'hA5);

        // 3. Single RX byte
        n0 = n_rx; nv = n_rxv;
        rxq.push_back(8'h3C);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (n_rx == n0 + 1) begin ok = 1'b1; break; end
        end
        chk("t3_done", 32'(ok), 32'h1);
        chk("t3_rx_data", {24'h0, rx_data_o}, 32'h3C);
        chk("t3_rx_valid_once", n_rxv - nv, 32'h1);

        // 4. Concurrent TX stream and RX stream after reset: strict alternation
        rst = 1'b1; step(); step(); rst = 1'b0;
        grants.delete();
        busy_len = $urandom_range(1, 12);
        n0 = n_rx;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            txq.push_back(b); tx_exp.push_back(b);
            rxq.push_back(8'($urandom));
        end
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (txq.size() == 0 && rxq.size() == 0 && !busy_o && n_rx == n0 + 4) begin ok = 1'b1; break; end
        end
        chk("t4_done", 32'(ok), 32'h1);
        chk("t4_grant_count", grants.size(), 32'd8);
        for (int i = 0; i < grants.size(); i++)
            chk("t4_grant_order", grants[i], (i % 2 == 0) ? 32'd1 : 32'd2);

        // 5. TX busy stuck after start: timeout then RX still served
        stick_next = 1'b1; busy_len = 4;
        txq.push_back(8'h99); tx_exp.push_back(8'h99);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (err_o) begin ok = 1'b1; break; end
        end
        chk("t5_err_set", 32'(ok), 32'h1);
        chk("t5_err_polls", err_cyc - go_cyc, TIMEOUT + 1);
        n0 = n_rx;
        rxq.push_back(8'h42);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (n_rx == n0 + 1) begin ok = 1'b1; break; end
        end
        chk("t5_rx_done", 32'(ok), 32'h1);
        chk("t5_rx_data", {24'h0, rx_data_o}, 32'h42);
        chk("t5_err_kept", 32'(err_o), 32'h1);

        // 6. Reset mid TX_WAIT, then mid RX_RD, then a clean TX
        stick_next = 1'b0; stuck = 1'b0; busy_len = 40; ng = n_go;
        txq.push_back(8'hC3); tx_exp.push_back(8'hC3);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (n_go == ng + 1) begin ok = 1'b1; break; end
        end
        chk("t6_go_seen", 32'(ok), 32'h1);
        step(); step(); step();
        chk("t6_in_wait", {30'h0, busy_o, reg_sel_o}, 32'h2);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_tx_ctl", {17'h0, tx_ready_o, rx_valid_o, rx_data_o, wr_o, reg_sel_o, addr_o, busy_o, err_o}, 32'h0);
        chk("t6_rst_tx_entrada", entrada_o, 32'h0);
        step(); step(); rst = 1'b0;

        rxq.push_back(8'h77);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (reg_sel_o && addr_o && !wr_o) begin ok = 1'b1; break; end
        end
        chk("t6_rx_rd_seen", 32'(ok), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_rx_ctl", {17'h0, tx_ready_o, rx_valid_o, rx_data_o, wr_o, reg_sel_o, addr_o, busy_o, err_o}, 32'h0);
        chk("t6_rst_rx_entrada", entrada_o, 32'h0);
        step(); step(); rst = 1'b0;

        busy_len = 3; ng = n_go;
        txq.push_back(8'h5A); tx_exp.push_back(8'h5A);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (n_go == ng + 1 && !busy_o) begin ok = 1'b1; break; end
        end
        chk("t6_tx_done", 32'(ok), 32'h1);
        chk("t6_tx_byte", {24'h0, ipu_tx_log[ipu_tx_log.size() - 1]}, 32'h5A);
        chk("t6_err_clear", 32'(err_o), 32'h0);

        // End-to-end TX scoreboard
        chk("tx_log_len", ipu_tx_log.size(), tx_exp.size());
        for (int i = 0; i < tx_exp.size() && i < ipu_tx_log.size(); i++)
            chk("tx_log_byte", {24'h0, ipu_tx_log[i]}, {24'h0, tx_exp[i]});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
